bram_slice_loader: RTL

Write-side loader for the bit-sliced BRAM. Accepts one 16-bit operand per processing-element lane as a stream of word-parallel beats, buffers a group of 16 words, transposes it, and drives the BRAM A write port. Each write cycle carries bit k of all 16 words, written to bit-address base+k. It sits between the host/DMA word stream and the BRAM; port B stays with the compute datapath.

---
 rtl/bram_slice_loader_pkg.sv | 28 ++
 rtl/bram_slice_loader_bit_transpose_buf.sv | 38 +++
 rtl/bram_slice_loader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bram_slice_loader_pkg.sv
// bram_slice_loader_pkg
//   Constants and types shared by the bit-sliced BRAM write loader.
//   LANES    : words per group, also the BRAM data width.
//   MAX_BITS : widest operand in bits.
//   DEPTH    : number of valid bit-addresses per BRAM column.
//   ADDR_W   : BRAM address width.
//   norm_bits(): maps the in_bits field onto the range 1..16.
package bram_slice_loader_pkg;

  localparam int LANES    = 16;
  localparam int MAX_BITS = 16;
  localparam int DEPTH    = 160;
  localparam int ADDR_W   = 10;

  localparam int LANE_W   = $clog2(LANES);     // beat / lane index
  localparam int KBIT_W   = $clog2(MAX_BITS);  // bit index within a word
  localparam int BITS_W   = 5;                 // precision field, 1..16

  // Per-buffer state: FILL = accepting beats, DRAIN = holding a full group
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} buf_state_e;

  // 0 means full precision; anything above MAX_BITS saturates.
  function automatic logic [BITS_W-1:0] norm_bits(input logic [BITS_W-1:0] b);
    if (b == '0 || b > BITS_W'(MAX_BITS)) return BITS_W'(MAX_BITS);
    return b;
  endfunction

endpackage

// File: rtl/bram_slice_loader_bit_transpose_buf.sv
// bit_transpose_buf
//   LANES x MAX_BITS register array. Rows are written one word at a time
//   (one row per lane); columns are read combinationally so that a single
//   bit position of every lane is available as one LANES-bit slice.
//   clk, reset  : clock, async active-low reset
//   wr_en       : write wr_word into row wr_lane
//   rd_bit      : column select
//   rd_col      : rd_col[i] = bit rd_bit of row i
module bit_transpose_buf
  import bram_slice_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [LANE_W-1:0]   wr_lane,
  input  logic [MAX_BITS-1:0] wr_word,
  input  logic [KBIT_W-1:0]   rd_bit,
  output logic [LANES-1:0]    rd_col
);

  logic [LANES-1:0][MAX_BITS-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_lane] = wr_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  always_comb begin
    rd_col = '0;
    for (int i = 0; i < LANES; i++) rd_col[i] = mem_q[i][rd_bit];
  end

endmodule

// File: rtl/bram_slice_loader.sv
// bram_slice_loader
//   Write-side loader for the bit-sliced BRAM. Collects LANES word beats
//   (beat j -> lane j), then drives BRAM port A with one bit-plane per cycle:
//   addra = base+k, dia[i] = bit k of lane i, k = 0..bits-1, LSB first.
//   Writes landing at or beyond DEPTH are suppressed and set the sticky err.
//
//   Ports: clk, reset (async active-low)
//          in_valid/in_ready/in_data/in_base/in_bits : word beat stream;
//            in_base/in_bits are sampled on beat 0 only
//          wea/addra/dia : registered BRAM port-A write
//          done  : registered pulse with the last write of a group
//          busy  : a buffer holds data or a drain is in progress
//          err   : sticky address-overflow flag
//
//   Build option: define BRAM_LOADER_DOUBLE_BUF_EN for two ping-pong
//   transpose buffers, so filling one overlaps draining the other.
module bram_slice_loader
  import bram_slice_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] in_data,
  input  logic [ADDR_W-1:0]   in_base,
  input  logic [BITS_W-1:0]   in_bits,
  output logic                wea,
  output logic [ADDR_W-1:0]   addra,
  output logic [LANES-1:0]    dia,
  output logic                done,
  output logic                busy,
  output logic                err
);

`ifdef BRAM_LOADER_DOUBLE_BUF_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  // Arrays are sized for two buffers; the single-buffer build keeps both
  // selects at 0 so the second slot stays idle.
  logic [LANE_W-1:0] beat_q, beat_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  buf_state_e        st_q [2];
  buf_state_e        st_d [2];
  logic [1:0]        pend_q, pend_d;       // group still has writes to issue
  logic [ADDR_W-1:0] base_q [2];
  logic [ADDR_W-1:0] base_d [2];
  logic [BITS_W-1:0] bits_q [2];
  logic [BITS_W-1:0] bits_d [2];
  logic [KBIT_W-1:0] k_q, k_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [LANES-1:0]  dia_q, dia_d;
  logic              done_q, done_d;
  logic              done_buf_q, done_buf_d;
  logic              err_q, err_d;

  logic              accept, fill_last, fill_into_rd, issue, last_k, in_range;
  logic [ADDR_W:0]   addr_sum;
  logic [LANES-1:0]  col [2];
  logic [LANES-1:0]  slice;

  // ---------------------------------------------------------------- buffers
  for (genvar b = 0; b < 2; b++) begin : g_buf
    if (b < NBUF) begin : g_on
      bit_transpose_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && (wr_sel_q == 1'(b))),
        .wr_lane (beat_q),
        .wr_word (in_data),
        .rd_bit  (k_q),
        .rd_col  (col[b])
      );
    end else begin : g_off
      assign col[b] = '0;
    end
  end

  // --------------------------------------------------------- datapath terms
  assign in_ready     = (st_q[wr_sel_q] == FILL);
  assign accept       = in_valid & in_ready;
  assign fill_last    = accept & (beat_q == LANE_W'(LANES-1));
  // The last beat is being written this very edge; drain starts without
  // waiting a cycle, so its lane-15 bit comes straight from in_data.
  assign fill_into_rd = fill_last & (wr_sel_q == rd_sel_q);
  assign issue        = pend_q[rd_sel_q] | fill_into_rd;
  assign addr_sum     = {1'b0, base_q[rd_sel_q]} + (ADDR_W+1)'(k_q);
  assign in_range     = addr_sum < (ADDR_W+1)'(DEPTH);
  assign last_k       = (({1'b0, k_q}) + BITS_W'(1)) == bits_q[rd_sel_q];

  always_comb begin
    slice = col[rd_sel_q];
    if (fill_into_rd) slice[LANES-1] = in_data[k_q];
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    beat_d     = beat_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    st_d       = st_q;
    pend_d     = pend_q;
    base_d     = base_q;
    bits_d     = bits_q;
    k_d        = k_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dia_d      = dia_q;
    done_d     = 1'b0;
    done_buf_d = done_buf_q;
    err_d      = err_q;

    // A buffer becomes refillable the cycle after its done is shown.
    if (done_q) st_d[done_buf_q] = FILL;

    if (accept) begin
      beat_d = beat_q + 1'b1;
      if (beat_q == '0) begin
        base_d[wr_sel_q] = in_base;
        bits_d[wr_sel_q] = norm_bits(in_bits);
      end
      if (fill_last) begin
        st_d[wr_sel_q]   = DRAIN;
        pend_d[wr_sel_q] = 1'b1;
        wr_sel_d         = (NBUF == 2) ? ~wr_sel_q : 1'b0;
      end
    end

    // Out-of-range writes still consume a slot; only wea is withheld.
    if (issue) begin
      wea_d      = in_range;
      addra_d    = addr_sum[ADDR_W-1:0];
      dia_d      = slice;
      done_buf_d = rd_sel_q;
      err_d      = err_q | ~in_range;
      if (last_k) begin
        done_d           = 1'b1;
        pend_d[rd_sel_q] = 1'b0;
        k_d              = '0;
        rd_sel_d         = (NBUF == 2) ? ~rd_sel_q : 1'b0;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      st_q       <= '{FILL, FILL};
      pend_q     <= '0;
      base_q     <= '{default: '0};
      bits_q     <= '{default: '0};
      k_q        <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dia_q      <= '0;
      done_q     <= 1'b0;
      done_buf_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      st_q       <= st_d;
      pend_q     <= pend_d;
      base_q     <= base_d;
      bits_q     <= bits_d;
      k_q        <= k_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dia_q      <= dia_d;
      done_q     <= done_d;
      done_buf_q <= done_buf_d;
      err_q      <= err_d;
    end
  end

  assign wea   = wea_q;
  assign addra = addra_q;
  assign dia   = dia_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (beat_q != '0) | (st_q[0] == DRAIN) | (st_q[1] == DRAIN);

endmodule
